// File: rtl/float_class_stats.sv
// rtl/float_class_stats.sv - per-class occurrence counters with snapshot-and-stream dump
// Optional macro FLOAT_CLASS_STATS_SAT_EN: live counters saturate instead of wrapping.
module float_class_stats #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [4:0]       float_type,
    input  logic             dump,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [2:0]       out_idx,
    output logic [CNT_W-1:0] out_count,
    output logic             busy,
    output logic             bad_type
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] live [5];
    logic [CNT_W-1:0] snap [5];

    logic       in_onehot;
    logic [4:0] hit;
    logic       dump_acc;
    logic       advance;
    logic       last_beat;
    logic [2:0] idx_nxt;

    assign in_onehot = (float_type != 5'd0) && ((float_type & (float_type - 5'd1)) == 5'd0);
    assign hit       = (in_valid && in_onehot) ? float_type : 5'd0;
    assign dump_acc  = (state == IDLE) && dump;
    assign advance   = (state == SEND) && out_ready && (out_idx != 3'd4);
    assign last_beat = (state == SEND) && out_ready && (out_idx == 3'd4);
    assign idx_nxt   = out_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dump_acc) state_nxt = SEND;
            SEND:    if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == SEND);
        busy      = (state == SEND);
    end

    // A hit on the dump edge lands in the freshly cleared counter, not the snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                live[i] <= '0;
                snap[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (dump_acc) begin
                    snap[i] <= live[i];
                    live[i] <= hit[i] ? CNT_W'(1) : '0;
                end else if (hit[i]) begin
`ifdef FLOAT_CLASS_STATS_SAT_EN
                    if (live[i] != {CNT_W{1'b1}}) begin
                        live[i] <= live[i] + CNT_W'(1);
                    end
`else
                    live[i] <= live[i] + CNT_W'(1);
`endif
                end
            end
        end
    end

    // Beat 0 is loaded straight from the live counter because snap is written on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_idx   <= 3'd0;
            out_count <= '0;
        end else if (dump_acc) begin
            out_idx   <= 3'd0;
            out_count <= live[0];
        end else if (advance) begin
            out_idx   <= idx_nxt;
            out_count <= snap[idx_nxt];
        end else if (last_beat) begin
            out_idx   <= 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bad_type <= 1'b0;
        end else if (in_valid && !in_onehot) begin
            bad_type <= 1'b1;
        end
    end

endmodule

// File: tb/tb_float_class_stats.sv
// tb/tb_float_class_stats.sv - directed self-checking bench for float_class_stats
module tb_float_class_stats;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [4:0]       float_type;
    logic             dump;
    logic             out_ready;
    logic             out_valid;
    logic [2:0]       out_idx;
    logic [CNT_W-1:0] out_count;
    logic             busy;
    logic             bad_type;

    int n_cmp;
    int n_err;

    float_class_stats #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .float_type (float_type),
        .dump       (dump),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_count  (out_count),
        .busy       (busy),
        .bad_type   (bad_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [4:0] ft, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid   = 1'b1;
            float_type = ft;
            step();
        end
        in_valid   = 1'b0;
        float_type = 5'd0;
    endtask

    // exp packs counts as {c4,c3,c2,c1,c0}; stall_n cycles of out_ready=0 are inserted at beat stall_idx.
    task automatic do_dump(input string tag, input logic [5*CNT_W-1:0] exp,
                           input int stall_idx, input int stall_n,
                           input logic sim_in, input logic [4:0] sim_ft);
        int beats;
        int cycles;
        int stalls;
        logic [CNT_W-1:0] e;
        dump       = 1'b1;
        out_ready  = 1'b1;
        in_valid   = sim_in;
        float_type = sim_ft;
        step();
        dump       = 1'b0;
        in_valid   = 1'b0;
        float_type = 5'd0;
        check({tag, "_lat_valid"}, out_valid, 1);
        beats  = 0;
        cycles = 0;
        stalls = stall_n;
        while (beats < 5 && cycles < 40) begin
            e = exp[beats*CNT_W +: CNT_W];
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_idx"}, out_idx, beats);
            check({tag, "_count"}, out_count, e);
            if (beats == stall_idx && stalls > 0) begin
                out_ready = 1'b0;
                stalls--;
            end else begin
                out_ready = 1'b1;
                beats++;
            end
            step();
            cycles++;
        end
        out_ready = 1'b0;
        check({tag, "_beats"}, beats, 5);
        check({tag, "_cycles"}, cycles, 5 + stall_n);
        check({tag, "_end_valid"}, out_valid, 0);
        check({tag, "_end_busy"}, busy, 0);
        check({tag, "_end_idx"}, out_idx, 0);
    endtask

    initial begin
        logic [CNT_W-1:0] width_exp;
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        float_type = 5'd0;
        dump       = 1'b0;
        out_ready  = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", out_idx, 0);
        check("rst_count", out_count, 0);
        check("rst_bad", bad_type, 0);

        // Histogram: zero x2, normal x3, NaN x1
        feed(5'b00001, 2);
        feed(5'b00010, 3);
        feed(5'b10000, 1);
        do_dump("hist", {4'd1, 4'd0, 4'd0, 4'd3, 4'd2}, -1, 0, 1'b0, 5'd0);

        // Same histogram with a 3-cycle stall on beat 2
        feed(5'b00001, 2);
        feed(5'b00010, 3);
        feed(5'b10000, 1);
        do_dump("bp", {4'd1, 4'd0, 4'd0, 4'd3, 4'd2}, 2, 3, 1'b0, 5'd0);

        // Input on the dump edge goes to the next window
        do_dump("sim1", {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, -1, 0, 1'b1, 5'b00010);
        step();
        do_dump("sim2", {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, -1, 0, 1'b0, 5'd0);

        // Non-one-hot inputs
        check("bad_before", bad_type, 0);
        feed(5'b00011, 1);
        check("bad_multi", bad_type, 1);
        feed(5'b00000, 1);
        check("bad_zero", bad_type, 1);
        do_dump("bad", {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, -1, 0, 1'b0, 5'd0);
        check("bad_sticky", bad_type, 1);

        // 17 infinities into a 4-bit counter
`ifdef FLOAT_CLASS_STATS_SAT_EN
        width_exp = 4'd15;
`else
        width_exp = 4'd1;
`endif
        feed(5'b01000, 17);
        do_dump("width", {4'd0, width_exp, 4'd0, 4'd0, 4'd0}, -1, 0, 1'b0, 5'd0);

        // Reset while streaming beat 3
        feed(5'b00100, 2);
        dump      = 1'b1;
        out_ready = 1'b1;
        step();
        dump = 1'b0;
        step();
        step();
        step();
        check("mid_idx3", out_idx, 3);
        out_ready = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        check("mid_valid", out_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_idx", out_idx, 0);
        check("mid_bad", bad_type, 0);
        step();
        check("mid_hold_valid", out_valid, 0);
        do_dump("post_rst", {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, -1, 0, 1'b0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
